// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels between two requesters and alu_arbiter
interface alu_arbiter_if;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] rsp_x, rsp_flags;
  logic       rsp_err;
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_x, rsp_flags, rsp_err
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_x, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters; define ALU_ARB_RR_EN for round-robin, else req0 has fixed priority
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [7:0]   alu_sel,
  input  logic [7:0]   alu_x,
  input  logic [7:0]   alu_flags,
  output logic [7:0]   flags_q,
  output logic         busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, op_q, op_d, x_q, x_d, fl_q, fl_d, flags_d, in_op;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d, err_q, err_d;
  logic       idle, gnt1, acc, legal, cap, rsp_hs;
`ifdef ALU_ARB_RR_EN
  logic       last_q, last_d;
  assign gnt1 = bus.req1_valid && (!bus.req0_valid || !last_q);
`else
  assign gnt1 = bus.req1_valid && !bus.req0_valid;
`endif
  assign idle           = rst_n && state_q == IDLE;
  assign bus.req0_ready = idle && bus.req0_valid && !gnt1;
  assign bus.req1_ready = idle && gnt1;
  assign acc            = bus.req0_ready || bus.req1_ready;
  assign in_op          = gnt1 ? bus.req1_op : bus.req0_op;
  assign legal          = (in_op >= 8'h01 && in_op <= 8'h0F) || in_op == 8'h80;
  assign cap            = state_q == ISSUE && cnt_q == 4'd0;
  assign rsp_hs         = state_q == RESP && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
  always_comb begin
    state_d = acc ? (legal ? ISSUE : RESP) : cap ? RESP : rsp_hs ? IDLE : state_q;
    a_d     = acc ? (gnt1 ? bus.req1_a : bus.req0_a) : a_q;
    b_d     = acc ? (gnt1 ? bus.req1_b : bus.req0_b) : b_q;
    op_d    = acc ? in_op : op_q;
    owner_d = acc ? gnt1 : owner_q;
    cnt_d   = acc ? 4'(SETTLE_CYCLES - 1) : state_q == ISSUE ? cnt_q - 4'd1 : cnt_q;
    x_d     = cap ? alu_x : acc ? 8'h00 : x_q;
    fl_d    = cap ? alu_flags : acc ? 8'h00 : fl_q;
    err_d   = acc ? !legal : err_q;
    flags_d = (cap && op_q != 8'h80) ? alu_flags : flags_q;
`ifdef ALU_ARB_RR_EN
    last_d  = acc ? gnt1 : last_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      fl_q    <= '0;
      err_q   <= 1'b0;
      flags_q <= '0;
`ifdef ALU_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      fl_q    <= fl_d;
      err_q   <= err_d;
      flags_q <= flags_d;
`ifdef ALU_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end
  assign bus.rsp0_valid = state_q == RESP && !owner_q;
  assign bus.rsp1_valid = state_q == RESP && owner_q;
  assign bus.rsp_x      = x_q;
  assign bus.rsp_flags  = fl_q;
  assign bus.rsp_err    = err_q;
  assign alu_a          = state_q == ISSUE ? a_q : 8'h00;
  assign alu_b          = state_q == ISSUE ? b_q : 8'h00;
  assign alu_sel        = state_q == ISSUE ? op_q : 8'h00;
  assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a stub ALU and hand-computed results
module tb_alu_arbiter;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic       clk, rst_n;
  logic [7:0] alu_a, alu_b, alu_sel, alu_x, alu_flags, flags_q;
  logic [7:0] alu_a4, alu_b4, alu_sel4, alu_x4, alu_flags4, flags_q4;
  logic       busy, busy4;
  int         n_chk, n_fail;
  alu_arbiter_if bus ();
  alu_arbiter_if bus4 ();
  alu_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_x(alu_x), .alu_flags(alu_flags), .flags_q(flags_q), .busy(busy)
  );
  alu_arbiter #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4),
    .alu_x(alu_x4), .alu_flags(alu_flags4), .flags_q(flags_q4), .busy(busy4)
  );
  function automatic logic [15:0] alu_fn(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic       v;
    x = s == 8'h01 ? a + b : s == 8'h02 ? a - b : s == 8'h03 ? a & b :
        s == 8'h04 ? (b == 8'h00 ? 8'hFF : a / b) : s == 8'h80 ? a : 8'h00;
    v = s == 8'h01 && a[7] == b[7] && x[7] != a[7];
    return {1'b0, v, 2'b00, s == 8'h03, x[7], 1'b0, x == 8'h00, x};
  endfunction
  assign {alu_flags, alu_x}   = alu_fn(alu_sel, alu_a, alu_b);
  assign {alu_flags4, alu_x4} = alu_fn(alu_sel4, alu_a4, alu_b4);
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input bit r, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input int hold, input int elat, input logic [7:0] ex, input logic [7:0] ef,
                     input bit eerr, input logic [7:0] efl, input string tag);
    int n;
    if (r) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1; bus.rsp1_ready = hold == 0;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1; bus.rsp0_ready = hold == 0;
    end
    #1;
    n = 0;
    while (!(r ? bus.req1_ready : bus.req0_ready) && n < 20) begin tick(); n++; end
    check({tag, " req_ready"}, r ? bus.req1_ready : bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n = 1;
    while (!(r ? bus.rsp1_valid : bus.rsp0_valid) && n < 40) begin tick(); n++; end
    check({tag, " latency"}, n, elat);
    check({tag, " rsp_x"}, bus.rsp_x, ex);
    check({tag, " rsp_flags"}, bus.rsp_flags, ef);
    check({tag, " rsp_err"}, bus.rsp_err, eerr);
    check({tag, " flags_q"}, flags_q, efl);
    check({tag, " other_valid"}, r ? bus.rsp0_valid : bus.rsp1_valid, 0);
    for (int i = 0; i < hold; i++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      tick();
      check($sformatf("%s stall%0d valid", tag, i), r ? bus.rsp1_valid : bus.rsp0_valid, 1);
      check($sformatf("%s stall%0d rsp_x", tag, i), bus.rsp_x, ex);
      check($sformatf("%s stall%0d rsp_flags", tag, i), bus.rsp_flags, ef);
      check($sformatf("%s stall%0d req_ready", tag, i), {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    tick();
    check({tag, " idle_after"}, busy, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask
  initial begin
    int g, n;
    clk = 1'b0; rst_n = 1'b0; n_chk = 0; n_fail = 0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0; bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req0_op = 8'h01;
    bus.req1_a = 8'h00; bus.req1_b = 8'h00; bus.req1_op = 8'h00;
    bus4.req0_valid = 1'b0; bus4.req1_valid = 1'b0; bus4.rsp0_ready = 1'b1; bus4.rsp1_ready = 1'b1;
    bus4.req0_a = 8'h00; bus4.req0_b = 8'h00; bus4.req0_op = 8'h00;
    bus4.req1_a = 8'h00; bus4.req1_b = 8'h00; bus4.req1_op = 8'h00;
    tick();
    tick();
    check("reset req0_ready", bus.req0_ready, 0);
    check("reset busy", busy, 0);
    check("reset flags_q", flags_q, 8'h00);
    check("reset rsp_x", bus.rsp_x, 8'h00);
    check("reset alu_sel", alu_sel, 8'h00);
    check("reset rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    run(0, 8'h7F, 8'h01, 8'h01, 0, 2, 8'h80, 8'h44, 0, 8'h44, "add_ovf");
    run(0, 8'hF0, 8'h0F, 8'h03, 0, 2, 8'h00, 8'h09, 0, 8'h09, "and_zero");
    run(1, 8'h5A, 8'h00, 8'h80, 0, 2, 8'h5A, 8'h00, 0, 8'h09, "mov");
    run(0, 8'h12, 8'h34, 8'h20, 0, 1, 8'h00, 8'h00, 1, 8'h09, "illegal");
    run(1, 8'h03, 8'h04, 8'h01, 5, 2, 8'h07, 8'h00, 0, 8'h00, "backpressure");
    bus.req0_a = 8'h01; bus.req0_b = 8'h01; bus.req0_op = 8'h01;
    bus.req1_a = 8'h02; bus.req1_b = 8'h02; bus.req1_op = 8'h01;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    g = 0; n = 0;
    while (g < 4 && n < 60) begin
      if (bus.req0_ready || bus.req1_ready) begin
        check($sformatf("contention grant%0d", g), bus.req1_ready, RR ? g % 2 : 0);
        g++;
      end
      tick();
      n++;
    end
    check("contention grants", g, 4);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("contention drain", busy, 0);
    bus4.req0_a = 8'd200; bus4.req0_b = 8'd7; bus4.req0_op = 8'h04; bus4.req0_valid = 1'b1;
    #1;
    check("div req_ready", bus4.req0_ready, 1);
    tick();
    bus4.req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("div settle%0d alu_sel", i), alu_sel4, 8'h04);
      check($sformatf("div settle%0d alu_a", i), alu_a4, 8'd200);
      check($sformatf("div settle%0d rsp_valid", i), bus4.rsp0_valid, 0);
      tick();
    end
    check("div rsp_valid", bus4.rsp0_valid, 1);
    check("div rsp_x", bus4.rsp_x, 8'h1C);
    check("div alu_sel released", alu_sel4, 8'h00);
    tick();
    check("div idle_after", busy4, 0);
    run(0, 8'h7F, 8'h01, 8'h01, 0, 2, 8'h80, 8'h44, 0, 8'h44, "add_again");
    bus.req0_a = 8'h7F; bus.req0_b = 8'h01; bus.req0_op = 8'h01; bus.req0_valid = 1'b1;
    #1;
    check("midrst req_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    check("midrst in_issue", alu_sel, 8'h01);
    rst_n = 1'b0;
    tick();
    check("midrst busy", busy, 0);
    check("midrst rsp_valid", bus.rsp0_valid, 0);
    check("midrst flags_q", flags_q, 8'h00);
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("midrst req0 wins", bus.req0_ready, 1);
    check("midrst req1 loses", bus.req1_ready, 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    tick();
    check("midrst no response", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
